spi_tx_queue: RTL and testbench

//  Transmit byte queue sitting directly upstream of the SPI SENDER stage.

---
 rtl/spi_tx_queue.sv | 122 ++++++++++++
 tb/tb_spi_tx_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_queue.sv
// spi_tx_queue: byte FIFO feeding the SPI sender holding register.
// Host pushes at clock rate. A two-state drain FSM loads one byte into the
// sender each time the sender reports empty while transmit is enabled.
// Optional feature macro: SPI_TXQ_WATERMARK_EN adds the low_water output
// (registered LEVEL <= LOW_MARK flag) and the LOW_MARK parameter.
module spi_tx_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
`ifdef SPI_TXQ_WATERMARK_EN
  ,parameter int LOW_MARK = 2
`endif
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [7:0]        data_in,
  input  logic              te,
  input  logic              sender_empty,
  output logic [7:0]        sender_data,
  output logic              sender_write,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow
`ifdef SPI_TXQ_WATERMARK_EN
  ,output logic             low_water
`endif
);

  localparam int LW = ADDR_W + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic              push, pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // full is sampled from the registered level, so a same-cycle pop never
  // frees room for a push; flush suppresses both sides.
  assign push = wr_en & ~full & ~clr;
  assign pop  = (state == S_IDLE) & te & sender_empty & ~empty & ~clr;

  // Next occupancy: shared by the level register and the watermark flag.
  always_comb begin
    level_nxt = level;
    if (clr)
      level_nxt = '0;
    else begin
      case ({push, pop})
        2'b10:   level_nxt = level + 1'b1;
        2'b01:   level_nxt = level - 1'b1;
        default: level_nxt = level;
      endcase
    end
  end

  // Storage array; deliberately not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Pointers, level, sticky overflow and the drain FSM with registered outputs.
  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      sender_data  <= 8'h00;
      sender_write <= 1'b0;
      state        <= S_IDLE;
    end else if (clr) begin
      // sender_data intentionally keeps the last delivered byte
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      sender_write <= 1'b0;
      state        <= S_IDLE;
    end else begin
      level <= level_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          sender_write <= 1'b0;
          if (pop) begin
            sender_data  <= mem[rd_ptr];
            sender_write <= 1'b1;
            rd_ptr       <= rd_ptr + 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          // hold off until the sender has visibly taken the byte, so a
          // single empty period can never see two loads
          sender_write <= 1'b0;
          if (!sender_empty) state <= S_IDLE;
        end
        default: begin
          sender_write <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_TXQ_WATERMARK_EN
  // Refill request, evaluated on next-state level so it tracks level exactly.
  always_ff @(posedge clk or negedge preset) begin
    if (!preset) low_water <= 1'b1;
    else         low_water <= (level_nxt <= LW'(LOW_MARK));
  end
`endif

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue with a scoreboard of expected sender bytes
// and a small sender responder that acknowledges loads after a set gap.
module tb_spi_tx_queue;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       preset, clr, wr_en, te, sender_empty;
  logic [7:0] data_in, sender_data;
  logic       sender_write, full, empty, overflow;
  logic [3:0] level;
`ifdef SPI_TXQ_WATERMARK_EN
  logic       low_water;
`endif

  int vecs   = 0;
  int miscmp = 0;

  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         obs_rd = 0;
  int         nwr    = 0;

  bit   auto_snd  = 1'b0;
  bit   snd_force = 1'b1;
  logic auto_val  = 1'b1;
  int   gap       = 1;

  assign sender_empty = auto_snd ? auto_val : snd_force;

  always #5 clk = ~clk;

  spi_tx_queue #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .preset(preset), .clr(clr), .wr_en(wr_en), .data_in(data_in),
    .te(te), .sender_empty(sender_empty), .sender_data(sender_data),
    .sender_write(sender_write), .full(full), .empty(empty), .level(level),
    .overflow(overflow)
`ifdef SPI_TXQ_WATERMARK_EN
    ,.low_water(low_water)
`endif
  );

  // capture every load the DUT presents to the sender
  initial forever begin
    @(negedge clk);
    if (preset && sender_write) begin
      obs_q.push_back(sender_data);
      nwr++;
    end
  end

  // sender model: take the byte, stay busy for gap cycles, report empty again
  initial forever begin
    @(negedge clk);
    if (auto_snd && sender_write) begin
      auto_val = 1'b0;
      repeat (gap) @(negedge clk);
      auto_val = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input bit acc);
    wr_en   = 1'b1;
    data_in = d;
    if (acc) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int c = 0;
    while (nwr < target && c < budget) begin
      tick();
      c++;
    end
    chk("write_count", nwr, target);
  endtask

  task automatic drain_chk(input string tag);
    while (obs_rd < obs_q.size()) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_extra"}, obs_q[obs_rd], 32'hFFFF_FFFF);
      end else begin
        chk(tag, obs_q[obs_rd], exp_q.pop_front());
      end
      obs_rd++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int lmin, lmax, base;
    logic [7:0] last;
    preset = 1'b0; clr = 1'b0; wr_en = 1'b0; te = 1'b0; data_in = 8'h00;

    // reset values, before any clock edge
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_write", sender_write, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", sender_data, 8'h00);
`ifdef SPI_TXQ_WATERMARK_EN
    chk("rst_lw", low_water, 1);
`endif
    @(negedge clk);
    preset = 1'b1;
    tick();

    // single byte, latency and one load per empty period
    te = 1'b1; snd_force = 1'b1;
    push(8'hA5, 1);
    chk("lat_empty", empty, 0);
    chk("lat_level", level, 1);
    chk("lat_write0", sender_write, 0);
    tick();
    chk("lat_write1", sender_write, 1);
    chk("lat_data", sender_data, 8'hA5);
    chk("lat_level0", level, 0);
    tick();
    chk("pulse_len", sender_write, 0);
    push(8'hB6, 1);
    tick(4);
    chk("no_double", nwr, 1);
    chk("held_level", level, 1);
    snd_force = 1'b0;
    tick();
    snd_force = 1'b1;
    tick();
    chk("reload_write", sender_write, 1);
    chk("reload_data", sender_data, 8'hB6);
    tick();
    drain_chk("single");
    snd_force = 1'b0;
    tick();
    te = 1'b0; snd_force = 1'b1;
    tick();

    // fill to full and overflow with transmit disabled
    for (int i = 1; i <= 9; i++) begin
      push(8'(i), i <= DEPTH);
      if (i == DEPTH) begin
        chk("fill_full", full, 1);
        chk("fill_ovf0", overflow, 0);
      end
    end
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    base = nwr;
    gap = 2; auto_snd = 1'b1; te = 1'b1;
    wait_writes(base + 8, 200);
    tick(5);
    drain_chk("fill_order");
    chk("fill_level", level, 0);
    chk("fill_ovf_sticky", overflow, 1);

    // streaming push and drain across pointer wrap
    te = 1'b0; gap = 1;
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 1);
    base = nwr;
    te = 1'b1;
    lmin = 99; lmax = 0;
    for (int i = 3; i < 23; i++) begin
      wr_en = 1'b1; data_in = 8'h40 + 8'(i); exp_q.push_back(data_in);
      tick();
      wr_en = 1'b0;
      if (int'(level) < lmin) lmin = int'(level);
      if (int'(level) > lmax) lmax = int'(level);
      tick();
      if (int'(level) < lmin) lmin = int'(level);
      if (int'(level) > lmax) lmax = int'(level);
    end
    chk("wrap_range", (lmax - lmin) <= 1, 1);
    chk("wrap_nofull", lmax < DEPTH, 1);
    wait_writes(base + 23, 200);
    tick(5);
    drain_chk("wrap_order");
    last = 8'h40 + 8'd22;

    // flush with a concurrent push
    te = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 0);
    chk("flush_pre", level, 5);
    clr = 1'b1; wr_en = 1'b1; data_in = 8'hEE;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_write", sender_write, 0);
    chk("flush_data", sender_data, last);
    base = nwr;
    te = 1'b1;
    tick(4);
    chk("flush_nowrite", nwr, base);
    chk("flush_level2", level, 0);

`ifdef SPI_TXQ_WATERMARK_EN
    // watermark tracks level crossing LOW_MARK on the same edge
    te = 1'b0; gap = 3;
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), 1);
    chk("lw_at3", low_water, 0);
    base = nwr;
    te = 1'b1;
    tick();
    te = 1'b0;
    chk("lw_lvl2", level, 2);
    chk("lw_rise", low_water, 1);
    push(8'h73, 1);
    chk("lw_lvl3", level, 3);
    chk("lw_fall", low_water, 0);
    te = 1'b1;
    wait_writes(base + 4, 200);
    tick(6);
    drain_chk("lw_order");
`endif

    // reset in the middle of a load
    te = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h90 + 8'(i), 0);
    chk("mid_ovf_pre", overflow, 1);
    gap = 2; te = 1'b1;
    begin
      int c = 0;
      while (sender_write !== 1'b1 && c < 20) begin
        tick();
        c++;
      end
    end
    chk("mid_write_pre", sender_write, 1);
    #2 preset = 1'b0;
    #1;
    chk("mid_write", sender_write, 0);
    chk("mid_level", level, 0);
    chk("mid_empty", empty, 1);
    chk("mid_full", full, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_data", sender_data, 8'h00);
    @(negedge clk);
    preset = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
